// File: rtl/riscv_lsu_pkg.sv
// Shared constants and helpers for the RV32I load/store unit.
package riscv_lsu_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // IO word indices (byte address bits [3:2] inside the IO region)
  localparam logic [1:0] IO_LED = 2'd0;
  localparam logic [1:0] IO_CNT = 2'd1;

  // Unsupported encodings and misaligned halfword/word accesses are rejected.
  function automatic logic access_illegal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      bad = f3[2] | (f3 == 3'b011);
    end else begin
      bad = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    if ((f3[1:0] == 2'b01) && off[0]) begin
      bad = 1'b1;
    end else if ((f3[1:0] == 2'b10) && (off != 2'b00)) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes so the mask alone selects bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request/response handshake plus the block-RAM port of the LSU.
interface riscv_lsu_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rstrb;
  logic [31:0]       mem_rdata;

  // LSU side
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );

  // Core + RAM side
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_wmask, mem_rstrb
  );
endinterface

// File: rtl/riscv_load_align.sv
// Picks the addressed byte/halfword lane of a load word and extends it to 32 bits.
module riscv_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign or zero extension
  always_comb begin
    case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'd0, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'd0, half_s};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: block-RAM port with byte masks, LED register and cycle counter.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int IO_BIT = 22,
  parameter int LED_W  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  riscv_lsu_if.slave       bus,
  output logic [LED_W-1:0] leds
);
  logic [1:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        io_idx_q, io_idx_d;
  logic              io_q, io_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic [LED_W-1:0]  led_wdata_q, led_wdata_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       io_word_q, io_word_d;
  logic [31:0]       cnt_q;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              mem_rstrb_q, mem_rstrb_d;
  logic [31:0]       word_sel_s;
  logic [31:0]       load_data_s;
  logic              addr_unused_s;

  // Upper address bits only alias the RAM; they carry no meaning here.
  assign addr_unused_s = ^{bus.req_addr[31:IO_BIT+1], bus.req_addr[IO_BIT-1:ADDR_W+2]};

  assign word_sel_s = io_q ? io_word_q : bus.mem_rdata;

  riscv_load_align u_align (
    .word_i   (word_sel_s),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data_s)
  );

  // Next-state and next-output decode for the access FSM
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    io_idx_d     = io_idx_q;
    io_d         = io_q;
    f3_d         = f3_q;
    store_d      = store_q;
    led_wdata_d  = led_wdata_q;
    led_d        = led_q;
    io_word_d    = io_word_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = 4'b0000;
    mem_rstrb_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          off_d       = bus.req_addr[1:0];
          io_idx_d    = bus.req_addr[3:2];
          io_d        = bus.req_addr[IO_BIT];
          f3_d        = bus.req_funct3;
          store_d     = bus.req_is_store;
          led_wdata_d = bus.req_wdata[LED_W-1:0];
          if (access_illegal(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            if (!bus.req_addr[IO_BIT]) begin
              mem_addr_d = bus.req_addr[ADDR_W+1:2];
              if (bus.req_is_store) begin
                mem_wmask_d = store_mask(bus.req_funct3, bus.req_addr[1:0]);
                mem_wdata_d = store_data(bus.req_funct3, bus.req_wdata);
              end else begin
                mem_rstrb_d = 1'b1;
              end
            end else begin
              mem_addr_d = mem_addr_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (store_q) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          if (io_q && (io_idx_q == IO_LED)) begin
            led_d = led_wdata_q;
          end else begin
            led_d = led_q;
          end
        end else begin
          state_d = ST_WAIT;
          case (io_idx_q)
            IO_LED:  io_word_d = 32'(led_q);
            IO_CNT:  io_word_d = cnt_q;
            default: io_word_d = 32'd0;
          endcase
        end
      end
      ST_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data_s;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // FSM, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      off_q        <= 2'd0;
      io_idx_q     <= 2'd0;
      io_q         <= 1'b0;
      f3_q         <= 3'd0;
      store_q      <= 1'b0;
      led_wdata_q  <= '0;
      led_q        <= '0;
      io_word_q    <= 32'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_wmask_q  <= 4'b0000;
      mem_rstrb_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      io_idx_q     <= io_idx_d;
      io_q         <= io_d;
      f3_q         <= f3_d;
      store_q      <= store_d;
      led_wdata_q  <= led_wdata_d;
      led_q        <= led_d;
      io_word_q    <= io_word_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_rstrb_q  <= mem_rstrb_d;
    end
  end

  // Free-running cycle counter, independent of the access FSM
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.mem_rstrb  = mem_rstrb_q;
  assign leds           = led_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed cases plus randomized traffic.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;
  localparam int ADDR_W = 12;
  localparam int IO_BIT = 22;
  localparam int LED_W  = 5;

  typedef struct {
    logic [31:0]      rdata;
    logic             err;
    int               cyc;
    logic [LED_W-1:0] led;
  } resp_t;

  typedef struct {
    int               cyc;
    logic [ADDR_W-1:0] addr;
    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic             rstrb;
  } mem_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [LED_W-1:0] leds;
  int               cyc = 0;
  int               n_chk = 0;
  int               n_pass = 0;
  logic [31:0]      ref_cnt;
  logic [31:0]      cnt_ofs = 32'd0;
  logic [LED_W-1:0] ref_led = '0;
  logic [7:0]       ref_mem [0:16383] = '{default: 8'h00};
  logic [31:0]      ram [0:4095] = '{default: 32'h0};
  resp_t            resp_q[$];
  mem_t             mem_q[$];
  resp_t            mon_r;
  mem_t             mon_m;

  riscv_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_lsu #(.ADDR_W(ADDR_W), .IO_BIT(IO_BIT), .LED_W(LED_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .leds   (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected counter: zero on reset, +1 every cycle
  always @(posedge clk) begin
    if (!resetn) ref_cnt <= 32'd0;
    else         ref_cnt <= ref_cnt + 32'd1;
  end

  // Block RAM behind the port: byte-masked write, registered read
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_wmask[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_rstrb) bus.mem_rdata <= ram[bus.mem_addr];
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3[1:0])
      2'd0:    return f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Monitor: pop expectations whenever the DUT presents a response or a RAM strobe
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.resp_valid) begin
        check("resp_expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() != 0) begin
          mon_r = resp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, mon_r.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(mon_r.err));
          check("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
          check("leds", 32'(leds), 32'(mon_r.led));
        end
      end
      if ((bus.mem_wmask != 4'b0000) || bus.mem_rstrb) begin
        check("strobe_expected", 32'(mem_q.size() != 0), 32'd1);
        if (mem_q.size() != 0) begin
          mon_m = mem_q.pop_front();
          check("mem_cycle", 32'(cyc), 32'(mon_m.cyc));
          check("mem_addr", 32'(bus.mem_addr), 32'(mon_m.addr));
          check("mem_wmask", 32'(bus.mem_wmask), 32'(mon_m.wmask));
          check("mem_rstrb", 32'(bus.mem_rstrb), 32'(mon_m.rstrb));
          if (mon_m.wmask != 4'b0000) check("mem_wdata", bus.mem_wdata, mon_m.wdata);
        end
      end
    end
  end

  // Present one request, wait for acceptance, then push the expected outcome
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
    int          waitc;
    int          sz;
    int          base;
    logic        ill;
    logic [31:0] w;
    int          mk;
    resp_t       r;
    mem_t        m;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    waitc = 0;
    while (!bus.req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sz  = 1 << f3[1:0];
    ill = st ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
    if (sz == 2 && a[0]) ill = 1'b1;
    if (sz == 4 && a[1:0] != 2'b00) ill = 1'b1;
    r.rdata = 32'd0;
    r.err   = 1'b0;
    if (ill) begin
      r.err = 1'b1;
      r.cyc = cyc;
    end else if (a[IO_BIT]) begin
      if (st) begin
        if (a[3:2] == 2'd0) ref_led = wd[LED_W-1:0];
        r.cyc = cyc + 1;
      end else begin
        if (a[3:2] == 2'd0)      w = 32'(ref_led);
        else if (a[3:2] == 2'd1) w = ref_cnt + cnt_ofs;
        else                     w = 32'd0;
        r.rdata = fmt_load(w, a[1:0], f3);
        r.cyc   = cyc + 2;
      end
    end else begin
      m.cyc  = cyc;
      m.addr = a[ADDR_W+1:2];
      if (st) begin
        base = int'(a[ADDR_W+1:0]);
        for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
        mk = ((1 << sz) - 1) << a[1:0];
        m.wmask = mk[3:0];
        for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        m.rstrb = 1'b0;
        r.cyc   = cyc + 1;
      end else begin
        base = int'(a[ADDR_W+1:2]) * 4;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[base + i];
        m.wmask = 4'b0000;
        m.wdata = 32'd0;
        m.rstrb = 1'b1;
        r.rdata = fmt_load(w, a[1:0], f3);
        r.cyc   = cyc + 2;
      end
      mem_q.push_back(m);
    end
    r.led = ref_led;
    resp_q.push_back(r);
    repeat (hold) @(posedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    check("rst_mem_rstrb", 32'(bus.mem_rstrb), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs();

    // Word store and load back
    issue(1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    issue(1'b0, F3_W, 32'h0000_0010, 32'h0, 0);
    // Byte store in the top lane, signed and unsigned reload
    issue(1'b1, F3_B, 32'h0000_0013, 32'h0000_0080, 0);
    issue(1'b0, F3_B, 32'h0000_0013, 32'h0, 0);
    issue(1'b0, F3_BU, 32'h0000_0013, 32'h0, 0);
    // Misaligned accesses
    issue(1'b0, F3_H, 32'h0000_0021, 32'h0, 0);
    issue(1'b1, F3_W, 32'h0000_0022, 32'h1234_5678, 0);
    // LED register write and read
    issue(1'b1, F3_W, 32'h0040_0000, 32'h0000_0015, 0);
    issue(1'b0, F3_W, 32'h0040_0000, 32'h0, 0);
    // Counter reads with idle gap
    issue(1'b0, F3_W, 32'h0040_0004, 32'h0, 0);
    repeat (13) @(posedge clk);
    issue(1'b0, F3_W, 32'h0040_0004, 32'h0, 0);
    repeat (4) @(posedge clk);

    // Counter wrap: preload near the top, read either side of the wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFF0;
    cnt_ofs = 32'hFFFF_FFF0 - ref_cnt - 32'd1;
    @(negedge clk);
    release dut.cnt_q;
    issue(1'b0, F3_W, 32'h0040_0004, 32'h0, 0);
    repeat (20) @(posedge clk);
    issue(1'b0, F3_W, 32'h0040_0004, 32'h0, 0);

    // Held request during a busy load is taken only once
    issue(1'b0, F3_HU, 32'h0000_0012, 32'h0, 2);
    issue(1'b1, F3_H, 32'h0000_0022, 32'h0000_ABCD, 1);

    // Reset while a load waits for RAM data
    issue(1'b0, F3_W, 32'h0000_0010, 32'h0, 0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    resp_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_leds", 32'(leds), 32'd0);
    check("abort_rstrb", 32'(bus.mem_rstrb), 32'd0);
    @(negedge clk);
    resetn  = 1'b1;
    ref_led = '0;
    cnt_ofs = 32'd0;
    repeat (4) @(posedge clk);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      a[IO_BIT] = ($urandom_range(0, 3) == 0);
      if (!a[IO_BIT]) a[ADDR_W+1:2] = 12'($urandom_range(0, 31));
      issue(st, f3, a, $urandom, $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int k = 0; k < 20 && resp_q.size() != 0; k++) @(negedge clk);
    check("drain_resp", 32'(resp_q.size()), 32'd0);
    check("drain_mem", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
